// File: rtl/serial_op_sequencer_if.sv
// Operand and result streams of serial_op_sequencer. The out_ovf flag exists
// only when SERIAL_SEQ_OVF_EN is defined.
interface serial_op_sequencer_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_a;
    logic [BIT_WIDTH-1:0] in_b;
    logic                 in_m;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH:0]   out_sum;
    logic                 out_m;
`ifdef SERIAL_SEQ_OVF_EN
    logic                 out_ovf;
`endif

    // master is the producer/consumer around the sequencer, slave is the sequencer
    modport master (
`ifdef SERIAL_SEQ_OVF_EN
        input  out_ovf,
`endif
        output in_valid, in_a, in_b, in_m, out_ready,
        input  in_ready, out_valid, out_sum, out_m
    );

    modport slave (
`ifdef SERIAL_SEQ_OVF_EN
        output out_ovf,
`endif
        input  in_valid, in_a, in_b, in_m, out_ready,
        output in_ready, out_valid, out_sum, out_m
    );
endinterface

// File: rtl/serial_op_sequencer.sv
// Buffers operand pairs, launches serial_top one operation at a time and holds each result
// for a downstream handshake. Optional signed-overflow flag: SERIAL_SEQ_OVF_EN.
module serial_op_sequencer #(
    parameter int BIT_WIDTH   = 8,
    parameter int DEPTH       = 4,
    parameter int ADD_LATENCY = 10
) (
    input  logic                       clock,
    input  logic                       resetn,
    serial_op_sequencer_if.slave       bus,
    output logic [BIT_WIDTH-1:0]       add_a,
    output logic [BIT_WIDTH-1:0]       add_b,
    output logic                       add_m,
    output logic                       add_start,
    input  logic [BIT_WIDTH:0]         add_sum,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(ADD_LATENCY + 1);
    localparam int ENT_W  = 2 * BIT_WIDTH + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic              full;
    logic              empty;
    logic              push;
    logic              launch;
    logic              release_now;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign bus.in_ready = resetn && !full;
    assign push         = bus.in_valid && bus.in_ready;
    // out_valid is always set while in HOLD, so out_ready alone completes the handshake
    assign release_now  = (state == HOLD) && bus.out_ready;
    assign launch       = !empty && ((state == IDLE) || release_now);
    assign busy         = (state != IDLE) || !empty;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_m, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !launch) begin
                count <= count + CNT_W'(1);
            end else if (launch && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_SEQ_OVF_EN
    localparam int MSB = BIT_WIDTH - 1;
    logic ovf_now;

    // Same-sign add or opposite-sign subtract whose result sign flips away from A
    assign ovf_now = ((add_a[MSB] ^ add_b[MSB]) == add_m) && (add_sum[MSB] != add_a[MSB]);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_m         <= 1'b0;
            add_start     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_m     <= 1'b0;
`ifdef SERIAL_SEQ_OVF_EN
            bus.out_ovf   <= 1'b0;
`endif
        end else begin
            add_start <= launch;
            if (launch) begin
                {add_m, add_a, add_b} <= mem[rd_ptr];
                wait_cnt              <= '0;
            end
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // wait_cnt holds (edges since launch - 1), so this is the ADD_LATENCY-th edge
                    if (wait_cnt == WAIT_W'(ADD_LATENCY - 1)) begin
                        bus.out_sum   <= add_sum;
                        bus.out_m     <= add_m;
                        bus.out_valid <= 1'b1;
`ifdef SERIAL_SEQ_OVF_EN
                        bus.out_ovf   <= ovf_now;
`endif
                        state         <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (release_now) begin
                        bus.out_valid <= 1'b0;
                        state         <= launch ? WAIT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
